// File: rtl/counter_programmer.sv
// ==== counter_programmer: writes PLR/ULR/LLR/CCR to a counter over a strobed bus, ====
// ==== optionally reads them back, starts the counter and supervises EC. Rev 1.0    ====
`default_nettype none

module counter_programmer #(
   parameter int STROBE_CYCLES  = 1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       cfg_valid_in,
   output logic       cfg_ready_out,
   input  logic [7:0] plr_in,
   input  logic [7:0] ulr_in,
   input  logic [7:0] llr_in,
   input  logic [7:0] ccr_in,
   input  logic       verify_en_in,
   input  logic       abort_in,
   output logic       ncs_out,
   output logic       nwr_out,
   output logic       nrd_out,
   output logic       a1_out,
   output logic       a0_out,
   output logic [7:0] bus_dout,
   output logic       bus_oe_out,
   input  logic [7:0] bus_din,
   output logic       start_out,
   input  logic       ec_in,
   input  logic       err_in,
   output logic       busy_out,
   output logic       done_out,
   output logic       fail_out,
   output logic [1:0] fail_code_out
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WR_SETUP  = 4'd1,
      S_WR_STROBE = 4'd2,
      S_WR_HOLD   = 4'd3,
      S_RD_STROBE = 4'd4,
      S_RD_HOLD   = 4'd5,
      S_START     = 4'd6,
      S_WAIT_EC   = 4'd7,
      S_DONE      = 4'd8,
      S_FAIL      = 4'd9
   } state_t;

   localparam logic [3:0]  STB_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_RANGE = 2'b01;
   localparam logic [1:0] CODE_RDBK  = 2'b10;
   localparam logic [1:0] CODE_TMO   = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  stb_q, stb_d;
   logic [15:0] wait_q, wait_d;
   logic [7:0]  plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
   logic        verify_q, verify_d;
   logic [7:0]  rd_q, rd_d;
   logic [1:0]  code_q, code_d;

   logic [7:0]  sel_val;
   logic        in_wr, in_rd, abortable;

   always_comb begin
      unique case (idx_q)
         2'd0:    sel_val = plr_q;
         2'd1:    sel_val = ulr_q;
         2'd2:    sel_val = llr_q;
         default: sel_val = ccr_q;
      endcase
   end

   assign in_wr     = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE) || (state_q == S_WR_HOLD);
   assign in_rd     = (state_q == S_RD_STROBE) || (state_q == S_RD_HOLD);
   assign abortable = in_wr || in_rd || (state_q == S_START) || (state_q == S_WAIT_EC);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      stb_d    = stb_q;
      wait_d   = wait_q;
      plr_d    = plr_q;
      ulr_d    = ulr_q;
      llr_d    = llr_q;
      ccr_d    = ccr_q;
      verify_d = verify_q;
      rd_d     = rd_q;
      code_d   = code_q;
      if (abort_in && abortable) begin
         state_d = S_FAIL;
         code_d  = CODE_TMO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cfg_valid_in) begin
                  plr_d    = plr_in;
                  ulr_d    = ulr_in;
                  llr_d    = llr_in;
                  ccr_d    = ccr_in;
                  verify_d = verify_en_in;
                  idx_d    = 2'd0;
                  stb_d    = 4'd0;
                  if ((plr_in < llr_in) || (plr_in > ulr_in)) begin
                     state_d = S_FAIL;
                     code_d  = CODE_RANGE;
                  end else begin
                     state_d = S_WR_SETUP;
                     code_d  = CODE_NONE;
                  end
               end
            end
            S_WR_SETUP: begin
               stb_d   = 4'd0;
               state_d = S_WR_STROBE;
            end
            S_WR_STROBE: begin
               if (stb_q == STB_LAST) state_d = S_WR_HOLD;
               else                   stb_d   = stb_q + 4'd1;
            end
            S_WR_HOLD: begin
               stb_d = 4'd0;
               idx_d = idx_q + 2'd1;
               if (idx_q != 2'd3)  state_d = S_WR_SETUP;
               else if (verify_q)  state_d = S_RD_STROBE;
               else                state_d = S_START;
            end
            S_RD_STROBE: begin
               if (stb_q == STB_LAST) begin
                  rd_d    = bus_din;
                  state_d = S_RD_HOLD;
               end else begin
                  stb_d = stb_q + 4'd1;
               end
            end
            S_RD_HOLD: begin
               stb_d = 4'd0;
               idx_d = idx_q + 2'd1;
               if (rd_q != sel_val) begin
                  state_d = S_FAIL;
                  code_d  = CODE_RDBK;
               end else if (idx_q == 2'd3) begin
                  state_d = S_START;
               end else begin
                  state_d = S_RD_STROBE;
               end
            end
            // stb_q doubles as the START phase bit: 0 = pulse cycle, 1 = quiet cycle
            S_START: begin
               if (err_in) begin
                  state_d = S_FAIL;
                  code_d  = CODE_TMO;
               end else if (stb_q == 4'd0) begin
                  stb_d = 4'd1;
               end else begin
                  wait_d  = 16'd0;
                  state_d = S_WAIT_EC;
               end
            end
            S_WAIT_EC: begin
               if (err_in) begin
                  state_d = S_FAIL;
                  code_d  = CODE_TMO;
               end else if (ec_in) begin
                  state_d = S_DONE;
               end else if (wait_q == TO_LAST) begin
                  state_d = S_FAIL;
                  code_d  = CODE_TMO;
               end else begin
                  wait_d = wait_q + 16'd1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= S_IDLE;
         idx_q    <= 2'd0;
         stb_q    <= 4'd0;
         wait_q   <= 16'd0;
         plr_q    <= 8'd0;
         ulr_q    <= 8'd0;
         llr_q    <= 8'd0;
         ccr_q    <= 8'd0;
         verify_q <= 1'b0;
         rd_q     <= 8'd0;
         code_q   <= CODE_NONE;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         stb_q    <= stb_d;
         wait_q   <= wait_d;
         plr_q    <= plr_d;
         ulr_q    <= ulr_d;
         llr_q    <= llr_d;
         ccr_q    <= ccr_d;
         verify_q <= verify_d;
         rd_q     <= rd_d;
         code_q   <= code_d;
      end
   end

   // Outputs decode only registered state, so strobes cannot glitch or overlap
   assign cfg_ready_out     = (state_q == S_IDLE);
   assign busy_out          = (state_q != S_IDLE);
   assign done_out          = (state_q == S_DONE);
   assign fail_out          = (state_q == S_FAIL);
   assign fail_code_out     = code_q;
   assign ncs_out           = !(abortable);
   assign nwr_out           = (state_q != S_WR_STROBE);
   assign nrd_out           = (state_q != S_RD_STROBE);
   assign {a1_out, a0_out}  = (in_wr || in_rd) ? idx_q : 2'b00;
   assign bus_dout          = in_wr ? sel_val : 8'd0;
   assign bus_oe_out        = in_wr;
   assign start_out         = (state_q == S_START) && (stb_q == 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_counter_programmer.sv
// Directed bench for counter_programmer: a trace model predicts every output per cycle.
`default_nettype none

module tb_counter_programmer;

   localparam int STB = 1;
   localparam int TO  = 40;
   localparam int P_WR = 0, P_RD = 1, P_ST = 2, P_WT = 3, P_END = 4, P_IDLE = 5;

   typedef struct packed {
      logic       ncs, nwr, nrd;
      logic [1:0] a;
      logic [7:0] dout;
      logic       oe, start, busy, done, fail, ready;
      logic [1:0] code;
   } ov_t;

   logic       clk_in = 1'b0;
   logic       reset_in, cfg_valid_in, cfg_ready_out, verify_en_in, abort_in;
   logic [7:0] plr_in, ulr_in, llr_in, ccr_in, bus_dout, bus_din;
   logic       ncs_out, nwr_out, nrd_out, a1_out, a0_out, bus_oe_out, start_out;
   logic       ec_in, err_in, busy_out, done_out, fail_out;
   logic [1:0] fail_code_out;

   always #5 clk_in = ~clk_in;

   counter_programmer #(.STROBE_CYCLES(STB), .TIMEOUT_CYCLES(TO)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .cfg_valid_in(cfg_valid_in),
      .cfg_ready_out(cfg_ready_out), .plr_in(plr_in), .ulr_in(ulr_in), .llr_in(llr_in),
      .ccr_in(ccr_in), .verify_en_in(verify_en_in), .abort_in(abort_in),
      .ncs_out(ncs_out), .nwr_out(nwr_out), .nrd_out(nrd_out), .a1_out(a1_out),
      .a0_out(a0_out), .bus_dout(bus_dout), .bus_oe_out(bus_oe_out), .bus_din(bus_din),
      .start_out(start_out), .ec_in(ec_in), .err_in(err_in), .busy_out(busy_out),
      .done_out(done_out), .fail_out(fail_out), .fail_code_out(fail_code_out)
   );

   // Counter register file model: latches written data, optionally corrupts one read
   logic [7:0] mem [4];
   int         corrupt_idx = -1;
   logic [7:0] corrupt_val = 8'd0;
   always @(posedge nwr_out) mem[{a1_out, a0_out}] = bus_dout;
   always @* bus_din = (corrupt_idx == int'({a1_out, a0_out})) ? corrupt_val : mem[{a1_out, a0_out}];

   int  tests = 0;
   int  fails = 0;
   ov_t exp_q[$];
   int  ph_q[$];
   int  wait0;

   function automatic ov_t mk(input logic ncs, nwr, nrd, input logic [1:0] a,
                              input logic [7:0] d, input logic oe, st, busy, dn, fl,
                              input logic [1:0] code);
      mk = '{ncs, nwr, nrd, a, d, oe, st, busy, dn, fl, !busy, code};
   endfunction

   function automatic ov_t dut_vec();
      ov_t v;
      v.ncs = ncs_out;  v.nwr = nwr_out;  v.nrd = nrd_out;  v.a = {a1_out, a0_out};
      v.dout = bus_dout; v.oe = bus_oe_out; v.start = start_out; v.busy = busy_out;
      v.done = done_out; v.fail = fail_out; v.ready = cfg_ready_out; v.code = fail_code_out;
      return v;
   endfunction

   task automatic chk(input string nm, input int k, input ov_t got, input ov_t exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s k=%0d got=%h exp=%h", nm, k, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic add(input ov_t v, input int ph);
      exp_q.push_back(v);
      ph_q.push_back(ph);
      if (ph == P_WT && wait0 < 0) wait0 = exp_q.size() - 1;
   endtask

   // Expected trace from the cycle after accept to the first IDLE cycle afterwards
   task automatic build(input logic [7:0] p, u, l, c, input bit ver, input int bad_idx,
                        input int ec_at, input int err_at, input int abort_at);
      logic [7:0] v [4];
      bit ended;
      v[0] = p; v[1] = u; v[2] = l; v[3] = c;
      exp_q.delete(); ph_q.delete(); wait0 = -1; ended = 0;
      if (int'(p) < int'(l) || int'(p) > int'(u)) begin
         add(mk(1,1,1,2'd0,8'd0,0,0,1,0,1,2'd1), P_END);
      end else begin
         for (int i = 0; i < 4; i++) begin
            add(mk(0,1,1,2'(i),v[i],1,0,1,0,0,2'd0), P_WR);
            repeat (STB) add(mk(0,0,1,2'(i),v[i],1,0,1,0,0,2'd0), P_WR);
            add(mk(0,1,1,2'(i),v[i],1,0,1,0,0,2'd0), P_WR);
         end
         if (ver) begin
            for (int i = 0; i < 4; i++) begin
               repeat (STB) add(mk(0,1,0,2'(i),8'd0,0,0,1,0,0,2'd0), P_RD);
               add(mk(0,1,1,2'(i),8'd0,0,0,1,0,0,2'd0), P_RD);
               if (i == bad_idx) begin
                  add(mk(1,1,1,2'd0,8'd0,0,0,1,0,1,2'd2), P_END);
                  ended = 1;
                  break;
               end
            end
         end
         if (!ended) begin
            add(mk(0,1,1,2'd0,8'd0,0,1,1,0,0,2'd0), P_ST);
            add(mk(0,1,1,2'd0,8'd0,0,0,1,0,0,2'd0), P_ST);
            for (int w = 0; w < TO; w++) begin
               add(mk(0,1,1,2'd0,8'd0,0,0,1,0,0,2'd0), P_WT);
               if (w == ec_at) begin
                  add(mk(1,1,1,2'd0,8'd0,0,0,1,1,0,2'd0), P_END);
                  break;
               end
               if (w == TO - 1) add(mk(1,1,1,2'd0,8'd0,0,0,1,0,1,2'd3), P_END);
            end
         end
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         if (ph_q[k] == P_END) break;
         if (k == abort_at || (k == err_at && (ph_q[k] == P_ST || ph_q[k] == P_WT))) begin
            while (exp_q.size() > k + 1) begin
               void'(exp_q.pop_back());
               void'(ph_q.pop_back());
            end
            add(mk(1,1,1,2'd0,8'd0,0,0,1,0,1,2'd3), P_END);
            break;
         end
      end
      add(mk(1,1,1,2'd0,8'd0,0,0,0,0,0,exp_q[exp_q.size()-1].code), P_IDLE);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the closing idle cycle
   task automatic run(input string nm, input logic [7:0] p, u, l, c, input bit ver,
                      input int bad_idx, input int ec_at, input int err_at, input int abort_at,
                      input int rst_at, input bit hold_valid,
                      output int st_k, output int dn_k, output int fl_k, output int fl_code);
      int  ec_k;
      ov_t got;
      ov_t rstv;
      rstv = mk(1,1,1,2'd0,8'd0,0,0,0,0,0,2'd0);
      build(p, u, l, c, ver, bad_idx, ec_at, err_at, abort_at);
      ec_k = (ec_at >= 0 && wait0 >= 0) ? wait0 + ec_at : -1;
      st_k = -1; dn_k = -1; fl_k = -1; fl_code = -1;
      corrupt_idx = bad_idx;
      corrupt_val = (bad_idx == 1) ? u + 8'd1 : p + 8'd1;
      plr_in = p; ulr_in = u; llr_in = l; ccr_in = c; verify_en_in = ver; cfg_valid_in = 1'b1;
      @(posedge clk_in); #1;
      cfg_valid_in = hold_valid;
      plr_in = ~p; ulr_in = ~u; llr_in = ~l; ccr_in = ~c; verify_en_in = ~ver;
      for (int k = 0; k < exp_q.size(); k++) begin
         ec_in = (k == ec_k); err_in = (k == err_at); abort_in = (k == abort_at);
         if (k == rst_at) begin
            #2 reset_in = 1'b1;
            #1 chk({nm, "_rst_async"}, k, dut_vec(), rstv);
            @(posedge clk_in); #1;
            chk({nm, "_rst_hold"}, k, dut_vec(), rstv);
            @(negedge clk_in) reset_in = 1'b0;
            ec_in = 1'b0; err_in = 1'b0; abort_in = 1'b0;
            @(posedge clk_in);
            @(negedge clk_in);
            chk({nm, "_rst_idle"}, k, dut_vec(), rstv);
            break;
         end
         @(negedge clk_in);
         got = dut_vec();
         chk(nm, k, got, exp_q[k]);
         tests++;
         if (!nwr_out && !nrd_out) begin
            fails++; $display("FAIL %s_overlap k=%0d nwr=0 nrd=0", nm, k);
         end
         tests++;
         if (bus_oe_out && !nrd_out) begin
            fails++; $display("FAIL %s_oe_rd k=%0d oe=1 nrd=0", nm, k);
         end
         if (got.start && st_k < 0) st_k = k;
         if (got.done && dn_k < 0) dn_k = k;
         if (got.fail && fl_k < 0) begin fl_k = k; fl_code = int'(got.code); end
         if (k < exp_q.size() - 1) begin
            @(posedge clk_in); #1;
         end
      end
      ec_in = 1'b0; err_in = 1'b0; abort_in = 1'b0; corrupt_idx = -1;
   endtask

   initial begin
      int s, d, f, fc;
      reset_in = 1'b1; cfg_valid_in = 1'b0; verify_en_in = 1'b0; abort_in = 1'b0;
      ec_in = 1'b0; err_in = 1'b0; plr_in = 8'd0; ulr_in = 8'd0; llr_in = 8'd0; ccr_in = 8'd0;
      #12;
      chk("reset", 0, dut_vec(), mk(1,1,1,2'd0,8'd0,0,0,0,0,0,2'd0));
      @(negedge clk_in) reset_in = 1'b0;
      @(negedge clk_in);
      chk("post_reset_idle", 0, dut_vec(), mk(1,1,1,2'd0,8'd0,0,0,0,0,0,2'd0));

      run("basic", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, 30, -1, -1, -1, 0, s, d, f, fc);
      chk_int("basic_start_k", s, 12); chk_int("basic_done_k", d, 45); chk_int("basic_fail_k", f, -1);

      run("verify_ok", 8'd10, 8'd20, 8'd5, 8'd2, 1, -1, 3, -1, -1, -1, 0, s, d, f, fc);
      chk_int("verify_ok_start_k", s, 20); chk_int("verify_ok_done_k", d, 26);

      run("verify_bad", 8'd10, 8'd20, 8'd5, 8'd2, 1, 1, 3, -1, -1, -1, 0, s, d, f, fc);
      chk_int("verify_bad_start_k", s, -1); chk_int("verify_bad_fail_k", f, 16);
      chk_int("verify_bad_code", fc, 2);

      run("range_lo", 8'd4, 8'd20, 8'd5, 8'd2, 0, -1, 3, -1, -1, -1, 0, s, d, f, fc);
      chk_int("range_lo_fail_k", f, 0); chk_int("range_lo_code", fc, 1);

      run("range_hi", 8'd21, 8'd20, 8'd5, 8'd2, 0, -1, 3, -1, -1, -1, 0, s, d, f, fc);
      chk_int("range_hi_fail_k", f, 0);

      run("timeout", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, -1, -1, -1, -1, 0, s, d, f, fc);
      chk_int("timeout_fail_k", f, 14 + TO); chk_int("timeout_code", fc, 3);

      // abort while idle must be ignored and the previous fail code kept
      @(negedge clk_in) abort_in = 1'b1;
      @(negedge clk_in);
      chk("idle_abort", 0, dut_vec(), mk(1,1,1,2'd0,8'd0,0,0,0,0,0,2'd3));
      abort_in = 1'b0;

      run("ec_at_tmo", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, TO - 1, -1, -1, -1, 0, s, d, f, fc);
      chk_int("ec_at_tmo_done_k", d, 14 + TO); chk_int("ec_at_tmo_fail_k", f, -1);

      run("abort_wr", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, 3, -1, 4, -1, 0, s, d, f, fc);
      chk_int("abort_wr_fail_k", f, 5); chk_int("abort_wr_code", fc, 3);

      run("err_start", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, 3, 12, -1, -1, 0, s, d, f, fc);
      chk_int("err_start_fail_k", f, 13); chk_int("err_start_start_k", s, 12);

      run("reset_wait", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, 30, -1, -1, 20, 0, s, d, f, fc);
      chk_int("reset_wait_done", d, -1); chk_int("reset_wait_fail", f, -1);

      run("hold1", 8'd10, 8'd20, 8'd5, 8'd2, 0, -1, 2, -1, -1, -1, 1, s, d, f, fc);
      chk_int("hold1_done_k", d, 17);
      run("hold2", 8'd5, 8'd20, 8'd5, 8'd7, 1, -1, 1, -1, -1, -1, 1, s, d, f, fc);
      chk_int("hold2_done_k", d, 24);
      run("hold3", 8'd20, 8'd20, 8'd5, 8'd9, 0, -1, 0, -1, -1, -1, 0, s, d, f, fc);
      chk_int("hold3_done_k", d, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/counter_programmer.md
COUNTER_PROGRAMMER -- requirements
Module: counter_programmer

Interface
REQ-001 Parameter: STROBE_CYCLES, default 1; number of cycles nwr_out/nrd_out are held low per access (range 1..15).
REQ-002 Parameter: TIMEOUT_CYCLES, default 4096; maximum cycles in WAIT_EC before timeout (range 1..65535).
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid_in  input  1  request to program and start the counter.
REQ-006 cfg_ready_out  output  1  high only in IDLE; a request is accepted when cfg_valid_in and cfg_ready_out are both high at a rising edge.
REQ-007 plr_in, ulr_in, llr_in, ccr_in  input  8 each  preload, upper-limit, lower-limit and cycle-count values.
REQ-008 verify_en_in  input  1  sampled at accept; 1 enables the read-back phase.
REQ-009 abort_in  input  1  synchronous abort request.
REQ-010 ncs_out, nwr_out, nrd_out  output  1 each  active-low counter bus controls.
REQ-011 a1_out, a0_out  output  1 each  counter register address: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
REQ-012 bus_dout  output  8  write data; bus_oe_out  output  1  drives the shared data bus when high; bus_din  input  8  read-back data.
REQ-013 start_out  output  1  start pulse to the counter.
REQ-014 ec_in, err_in  input  1 each  end-of-cycle and range-error flags from the counter.
REQ-015 busy_out  output  1  high in every state except IDLE.
REQ-016 done_out  output  1  one-cycle pulse on successful completion.
REQ-017 fail_out  output  1  one-cycle pulse on failure; fail_code_out  output  2  00 none, 01 range, 10 read-back, 11 timeout or err_in.

Function
REQ-018 States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_HOLD, START, WAIT_EC, DONE, FAIL.
REQ-019 At accept, latch all four values and verify_en_in into internal registers; later changes on the inputs are ignored.
REQ-020 At accept, if plr < llr or plr > ulr: go to FAIL with code 01 and generate no bus activity.
REQ-021 Otherwise enter WR_SETUP with index 0.
REQ-022 Write sequence order: PLR, ULR, LLR, CCR.
REQ-023 Per register: WR_SETUP for 1 cycle (ncs=0, address and data valid, bus_oe=1, nwr=1), then WR_STROBE for STROBE_CYCLES (nwr=0), then WR_HOLD for 1 cycle (nwr=1, data still driven).
REQ-024 Address and data are stable from WR_SETUP through WR_HOLD.
REQ-025 After the index-3 write: if verify is set, enter RD_STROBE with index 0; otherwise enter START.
REQ-026 Read phase: bus_oe=0 and nwr=1 throughout; RD_STROBE holds nrd=0 for STROBE_CYCLES and samples bus_din on its last cycle; RD_HOLD lasts 1 cycle with nrd=1.
REQ-027 A read-back mismatch against the latched value goes to FAIL with code 10 at the end of the RD_HOLD cycle.
REQ-028 After all four reads match, go to START.
REQ-029 START is 2 cycles: start_out=1 in the first cycle, 0 in the second.
REQ-030 If err_in=1 in either START cycle, go to FAIL with code 11.
REQ-031 After START, enter WAIT_EC.
REQ-032 ncs_out stays 0 continuously from the first WR_SETUP through the last WAIT_EC cycle.
REQ-033 WAIT_EC: a 16-bit cycle counter clears on entry; ec_in=1 goes to DONE.
REQ-034 WAIT_EC: err_in=1, or the counter reaching TIMEOUT_CYCLES-1 without ec_in, goes to FAIL with code 11.
REQ-035 WAIT_EC: if ec_in and timeout occur in the same cycle, ec_in wins.
REQ-036 DONE and FAIL each last 1 cycle: ncs=1, done_out or fail_out pulsed, then return to IDLE.
REQ-037 fail_code_out holds its value until the next accept, which clears it to 00.
REQ-038 abort_in=1 in any busy state other than DONE/FAIL: next cycle all bus controls go inactive and the block enters FAIL with code 11.
REQ-039 abort_in in IDLE is ignored.
REQ-040 cfg_valid_in while busy is not accepted, and there is no queueing.
REQ-041 Output decode from state registers: nwr_out and nrd_out are never low simultaneously, and bus_oe_out is never high while nrd_out=0.

Reset
REQ-042 While reset_in=1, immediately: state=IDLE; ncs, nwr and nrd = 1; a1/a0=00; bus_dout=0; bus_oe=0; start_out=0.
REQ-043 While reset_in=1, immediately: busy, done and fail = 0; fail_code=00; cfg_ready=1 once reset is released; latched registers and counters = 0.
REQ-044 Reset mid-sequence abandons the transaction with no done or fail pulse.

Verification
REQ-045 plr=10, ulr=20, llr=5, ccr=2, verify=0, STROBE=1 -> four writes at 3 cycles each (12 cycles, addresses 00,01,10,11, data 10,20,5,2), then start pulse; ec_in at cycle 30 of WAIT_EC -> done_out=1, ncs high the following cycle.
REQ-046 Same values with verify=1, bus_din model returning written data -> four reads after the writes, then START; returning 21 for ULR -> fail_out with code 10 and no start_out.
REQ-047 plr=4, llr=5, ulr=20 -> fail_out the cycle after accept, code 01, ncs never low.
REQ-048 TIMEOUT_CYCLES=8, ec_in held 0 -> fail code 11 exactly 8 cycles after WAIT_EC entry; ec_in and timeout in the same cycle -> done_out.
REQ-049 abort_in during the second WR_STROBE -> controls inactive, fail code 11; reset_in pulsed during WAIT_EC -> all outputs at reset values asynchronously, no done or fail pulse.
REQ-050 cfg_valid_in held high through a full run -> exactly one accept per IDLE visit; nwr/nrd overlap and bus_oe-during-read assertions never fire.
